decode_stage: RTL

- Downstream neighbour of the fetch stage. Accepts {pc, instruction} pairs over a valid/ready handshake.
- Buffers the pairs in a small FIFO and decodes each into register indices, sign-extended immediate, opcode class and illegal flag.
- Holds the decoded result in an output register for the execute stage.
- Decouples fetch from execute stalls and supports flush on redirect (branch/jump).

---
 rtl/rv64_pkg.sv | 80 ++++++++
 rtl/decode_fifo.sv | 51 +++++
 rtl/decode_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rv64_pkg.sv
// rv64_pkg: RV64 opcodes, decode types and the combinational instruction decoder
package rv64_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_MISCMEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        OC_LUI, OC_AUIPC, OC_JAL, OC_JALR, OC_BRANCH, OC_LOAD, OC_STORE,
        OC_OPIMM, OC_OPIMM32, OC_OP, OC_OP32, OC_FENCE, OC_SYSTEM, OC_ILLEGAL
    } opclass_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_e;

    typedef enum logic {HS_RUN, HS_HALTED} halt_e;

    // imm is held as a 32-bit signed value; the stage sign-extends it to XLEN
    typedef struct packed {
        opclass_e    opclass;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } decoded_t;

    function automatic decoded_t decode(input logic [31:0] i);
        decoded_t d;
        imm_fmt_e f;
        d = '0;
        d.opclass = OC_ILLEGAL;
        f = IMM_NONE;
        case (i[6:0])
            OPC_LUI:     begin d.opclass = OC_LUI;     f = IMM_U;    end
            OPC_AUIPC:   begin d.opclass = OC_AUIPC;   f = IMM_U;    end
            OPC_JAL:     begin d.opclass = OC_JAL;     f = IMM_J;    end
            OPC_JALR:    begin d.opclass = OC_JALR;    f = IMM_I;    end
            OPC_BRANCH:  begin d.opclass = OC_BRANCH;  f = IMM_B;    end
            OPC_LOAD:    begin d.opclass = OC_LOAD;    f = IMM_I;    end
            OPC_STORE:   begin d.opclass = OC_STORE;   f = IMM_S;    end
            OPC_OPIMM:   begin d.opclass = OC_OPIMM;   f = IMM_I;    end
            OPC_OPIMM32: begin d.opclass = OC_OPIMM32; f = IMM_I;    end
            OPC_OP:      begin d.opclass = OC_OP;      f = IMM_NONE; end
            OPC_OP32:    begin d.opclass = OC_OP32;    f = IMM_NONE; end
            OPC_MISCMEM: begin d.opclass = OC_FENCE;   f = IMM_I;    end
            OPC_SYSTEM:  begin d.opclass = OC_SYSTEM;  f = IMM_I;    end
            default:     ;
        endcase
        d.illegal = (i[1:0] != 2'b11) || (d.opclass == OC_ILLEGAL);
        if (d.illegal) begin
            d.opclass = OC_ILLEGAL;
            f = IMM_NONE;
        end
        d.rd     = i[11:7];
        d.rs1    = i[19:15];
        d.rs2    = i[24:20];
        d.funct3 = i[14:12];
        d.funct7 = i[31:25];
        d.imm = (f == IMM_I) ? {{20{i[31]}}, i[31:20]} :
                (f == IMM_S) ? {{20{i[31]}}, i[31:25], i[11:7]} :
                (f == IMM_B) ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
                (f == IMM_U) ? {i[31:12], 12'b0} :
                (f == IMM_J) ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
                32'b0;
        return d;
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// decode_fifo: DEPTH-entry FIFO of {pc, instr} pairs with synchronous clear
module decode_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally modulo the power-of-two depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: buffers fetched {pc, instr} pairs and presents them decoded to execute.
// Optional DECODE_ILLEGAL_HALT_EN: halt after an illegal instruction is consumed.
module decode_stage
    import rv64_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [3:0]      out_opclass,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    logic [XLEN+31:0] head;
    logic [XLEN+31:0] ld_word;
    logic             fifo_empty;
    logic             fifo_full;
    logic             halted;
    logic             stop;
    logic             in_fire;
    logic             load_en;
    logic             pop;
    logic             push;
    logic             bypass;
    logic             load;
    logic             valid_q;
    logic [XLEN-1:0]  pc_q;
    logic [31:0]      instr_q;
    decoded_t         dec_q;

    assign in_ready = !reset && !fifo_full && !halted;
    assign in_fire  = in_valid && in_ready;
    assign load_en  = (!valid_q || out_ready) && !stop && !flush;
    assign pop      = load_en && !fifo_empty;
    assign bypass   = load_en && fifo_empty && in_fire;
    assign push     = in_fire && !bypass && !flush;
    assign load     = pop || bypass;
    assign ld_word  = pop ? head : {in_pc, in_instr};

    decode_fifo #(.W(XLEN + 32), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({in_pc, in_instr}),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef DECODE_ILLEGAL_HALT_EN
    halt_e state_q;
    halt_e state_d;

    // Halt state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= HS_RUN;
        else state_q <= state_d;
    end

    // Enter HALTED when an illegal instruction is consumed; flush releases it
    always_comb begin
        state_d = state_q;
        state_d = flush ? HS_RUN : (valid_q && out_ready && dec_q.illegal) ? HS_HALTED : state_q;
    end

    assign halted = (state_q == HS_HALTED);
    assign stop   = halted || (valid_q && out_ready && dec_q.illegal);
`else
    assign halted = 1'b0;
    assign stop   = 1'b0;
`endif

    // Output register: refills whenever empty or being consumed, FIFO head first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            dec_q   <= '0;
        end else begin
            if (flush) valid_q <= 1'b0;
            else if (!valid_q || out_ready) valid_q <= load;
            if (load) begin
                pc_q    <= ld_word[XLEN+31:32];
                instr_q <= ld_word[31:0];
                dec_q   <= decode(ld_word[31:0]);
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_instr   = instr_q;
    assign out_opclass = dec_q.opclass;
    assign out_rd      = dec_q.rd;
    assign out_rs1     = dec_q.rs1;
    assign out_rs2     = dec_q.rs2;
    assign out_funct3  = dec_q.funct3;
    assign out_funct7  = dec_q.funct7;
    assign out_imm     = {{(XLEN-32){dec_q.imm[31]}}, dec_q.imm};
    assign out_illegal = dec_q.illegal;

endmodule
